// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_arbiter
// Purpose  : Merges the in-order pipeline WB write and the long-latency
//            mul/div result onto the single register-file write port.
//            Pipeline writes always win. Mul/div results wait in a small FIFO
//            and drain into free write slots. A pending-destination mask
//            feeds hazard detection. A stall request keeps the FIFO from
//            starving.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            a_valid/a_addr/a_data  - pipeline WB write request
//            b_valid/b_ready/b_addr/b_data - mul/div result handshake
//            we/waddr/wd            - registered register-file write port
//            busy_mask  - bit i set while any queued entry targets x[i]
//            stall_req  - registered request to hold a_valid low
// Revision : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wd,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH + 1);
  localparam int C_STV_W = $clog2(STARVE_LIMIT + 1);

  // FIFO storage and state
  logic [4:0]         addr_q [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [C_PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [C_CNT_W-1:0] count_q, count_d;

  // Starvation tracking
  logic [C_STV_W-1:0] starve_q, starve_d;
  logic               stall_q;

  // Registered write port
  logic               we_q;
  logic [4:0]         waddr_q;
  logic [31:0]        wd_q;

  logic               w_a_win;
  logic               w_fifo_ne;
  logic               w_pop;
  logic               w_xfer;
  logic               w_push;

  // A write to x0 is a no-op, so it frees the slot for the FIFO.
  assign w_a_win   = a_valid && (a_addr != 5'd0);
  assign w_fifo_ne = (count_q != '0);
  assign w_pop     = !w_a_win && w_fifo_ne;

  // Ready comes from registered count only: a same-cycle pop never makes
  // room for a push when full.
  assign b_ready   = (count_q < C_CNT_W'(DEPTH));
  assign w_xfer    = b_valid && b_ready;
  // x0 results complete the handshake but are never queued.
  assign w_push    = w_xfer && (b_addr != 5'd0);

  // Pointers differ whenever both push and pop fire (pop needs non-empty,
  // push needs not-full), so the two valid-bit updates never collide.
  always_comb begin
    vld_d = vld_q;
    if (w_pop)  vld_d[rd_ptr_q] = 1'b0;
    if (w_push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    count_d = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
  end

  // Counter resets on any pop or an empty FIFO; otherwise a non-empty FIFO
  // that did not pop means A won the slot.
  always_comb begin
    starve_d = starve_q;
    if (!w_fifo_ne || w_pop) begin
      starve_d = '0;
    end else if (w_a_win && (starve_q < C_STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wd_q     <= '0;
    end else begin
      if (w_push) begin
        addr_q[wr_ptr_q] <= b_addr;
        data_q[wr_ptr_q] <= b_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      vld_q    <= vld_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      // Registered copy of (counter == limit), aligned with the counter.
      stall_q  <= (starve_d == C_STV_W'(STARVE_LIMIT));

      if (w_a_win) begin
        we_q    <= 1'b1;
        waddr_q <= a_addr;
        wd_q    <= a_data;
      end else if (w_pop) begin
        we_q    <= 1'b1;
        waddr_q <= addr_q[rd_ptr_q];
        wd_q    <= data_q[rd_ptr_q];
      end else begin
        // Address/data hold their last value on idle cycles.
        we_q    <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy_mask = busy_mask | (32'd1 << addr_q[i]);
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wd        = wd_q;
  assign stall_req = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_arbiter
// Purpose  : Self-checking bench for wb_write_arbiter. Stimulus pushes the
//            expected register-file writes into a queue; a monitor pops and
//            compares every cycle the DUT asserts we. Status outputs are
//            checked directly against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wd;
  logic [31:0] busy_mask;
  logic        stall_req;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  wb_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .we        (we),
    .waddr     (waddr),
    .wd        (wd),
    .busy_mask (busy_mask),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every asserted we must match the queue head.
  always @(negedge clk) begin
    if (rst && we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got waddr=%0d wd=%h, expected no write", waddr, wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (waddr !== e.a || wd !== e.d) begin
          n_fail++;
          $display("FAIL write: got waddr=%0d wd=%h, expected waddr=%0d wd=%h",
                   waddr, wd, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b0;
    a_valid = 1'b0;
    a_addr  = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_addr  = '0;
    b_data  = '0;

    // 1. Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we",    we,        0);
    chk("rst_busy",  busy_mask, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b1;
    step();
    chk("idle_bready", b_ready, 1);
    chk("idle_we",     we,      0);

    // 2. Pipeline only
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234_5678;
    expect_wr(5'd5, 32'h1234_5678);
    step();
    a_valid = 1'b0;
    step();
    chk("hold_waddr", waddr, 5);
    chk("hold_wd",    wd,    32'h1234_5678);

    // 3. Contention
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h1111_0001;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hABCD_EF12;
    expect_wr(5'd3, 32'h1111_0001);
    step();
    b_valid = 1'b0;
    chk("cont_busy1", busy_mask, 32'h0000_0400);
    a_data = 32'h1111_0002;
    expect_wr(5'd3, 32'h1111_0002);
    step();
    chk("cont_busy2", busy_mask, 32'h0000_0400);
    a_valid = 1'b0;
    expect_wr(5'd10, 32'hABCD_EF12);
    step();
    chk("cont_busy3", busy_mask, 0);
    step();

    // 4. Full FIFO: A holds the port while 7 and 8 fill the FIFO; 9 stalls
    a_valid = 1'b1; a_addr = 5'd1;
    for (int i = 0; i < 4; i++) begin
      a_data  = 32'hA000_0000 + i;
      b_valid = 1'b1;
      b_addr  = (i == 0) ? 5'd7 : (i == 1) ? 5'd8 : 5'd9;
      b_data  = (i == 0) ? 32'h70 : (i == 1) ? 32'h80 : 32'h90;
      expect_wr(5'd1, 32'hA000_0000 + i);
      step();
      if (i == 1) chk("full_bready", b_ready, 0);
    end
    chk("full_bready2", b_ready,   0);
    chk("full_busy",    busy_mask, (32'd1 << 7) | (32'd1 << 8));
    chk("full_stall",   stall_req, 0);
    a_valid = 1'b0;
    expect_wr(5'd7, 32'h70);
    expect_wr(5'd8, 32'h80);
    expect_wr(5'd9, 32'h90);
    step();                        // pop 7, full so 9 still waits
    chk("drain_bready", b_ready, 1);
    step();                        // pop 8, push 9
    b_valid = 1'b0;
    chk("drain_busy9", busy_mask, 32'd1 << 9);
    step();                        // pop 9
    chk("drain_busy0", busy_mask, 0);
    step();

    // 5. Starvation
    a_valid = 1'b1; a_addr = 5'd2;
    for (int i = 0; i < 5; i++) begin
      a_data  = 32'hB000_0000 + i;
      b_valid = (i == 0);
      b_addr  = 5'd12;
      b_data  = 32'h0000_0C12;
      expect_wr(5'd2, 32'hB000_0000 + i);
      step();
      if (i == 3) chk("starve_pre", stall_req, 0);
    end
    b_valid = 1'b0;
    chk("starve_set", stall_req, 1);
    a_valid = 1'b0;
    expect_wr(5'd12, 32'h0000_0C12);
    step();
    chk("starve_clr",  stall_req, 0);
    chk("starve_busy", busy_mask, 0);
    step();

    // 6a. b push to x0 is accepted and dropped
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hDEAD_BEEF;
    step();
    b_valid = 1'b0;
    chk("x0b_busy",   busy_mask, 0);
    chk("x0b_bready", b_ready,   1);
    step();
    chk("x0b_we",     we,        0);

    // 6b. a write to x0 frees the slot for the queued entry
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44;
    expect_wr(5'd6, 32'h66);
    step();
    b_valid = 1'b0;
    chk("x0a_busy4", busy_mask, 32'd1 << 4);
    a_addr = 5'd0; a_data = 32'h99;
    expect_wr(5'd4, 32'h44);
    step();
    a_valid = 1'b0;
    chk("x0a_busy0", busy_mask, 0);
    step();

    // 6c. Asynchronous reset with two entries queued
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h61;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h20;
    expect_wr(5'd6, 32'h61);
    step();
    b_addr = 5'd21; b_data = 32'h21; a_data = 32'h62;
    // This A write lands on the edge but reset wipes it before it is sampled.
    step();
    chk("pre_rst_busy", busy_mask, (32'd1 << 20) | (32'd1 << 21));
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk("arst_busy",  busy_mask, 0);
    chk("arst_we",    we,        0);
    chk("arst_stall", stall_req, 0);
    step();
    rst = 1'b1;
    step();
    step();
    chk("post_rst_busy", busy_mask, 0);
    chk("post_rst_we",   we,        0);
    chk("post_rst_bready", b_ready, 1);
    chk("pending_writes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Merges two register-file write sources onto the single register-file write port (we/waddr/wd): the in-order pipeline WB stage and the long-latency RV32IM mul/div unit.
- Pipeline writes always win; mul/div results are buffered in a small FIFO and drained into free write slots.
- Exports a pending-destination mask for hazard detection and a stall request that prevents mul/div starvation.
- Sits between the WB stage / mul-div unit and reg_files.

Parameters:
- DEPTH, 2, mul/div result FIFO entries (power of two, at least 2).
- STARVE_LIMIT, 4, consecutive cycles of a non-empty FIFO losing arbitration before stall_req asserts.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active low.
- a_valid  input  1  pipeline WB write request.
- a_addr  input  5  pipeline destination register.
- a_data  input  32  pipeline write data.
- b_valid  input  1  mul/div result valid.
- b_ready  output  1  FIFO can accept a mul/div result.
- b_addr  input  5  mul/div destination register.
- b_data  input  32  mul/div result.
- we  output  1  register-file write enable.
- waddr  output  5  register-file write address.
- wd  output  32  register-file write data.
- busy_mask  output  32  bit i = 1 when any valid FIFO entry targets register i.
- stall_req  output  1  request for the pipeline to hold a_valid low.

Behaviour:
- Reset (rst = 0, asynchronous):
  - we, waddr, wd, stall_req and busy_mask are 0.
  - FIFO is empty, pointers and count are 0, starve counter is 0.
  - b_ready is 1 once rst deasserts.
- Output timing: we/waddr/wd are registered. A write selected in cycle n appears after the rising edge ending cycle n. reg_files commits it on the following edge.
- Arbitration, evaluated each cycle:
  1. If a_valid = 1 and a_addr != 0, register A: we = 1, waddr = a_addr, wd = a_data.
  2. Otherwise, if the FIFO is non-empty, pop the head and register it with we = 1.
  3. Otherwise we = 0; waddr and wd hold their previous values.
- x0 handling:
  - a_valid with a_addr = 0 counts as an idle slot, so the FIFO may drain in that cycle.
  - A b handshake with b_addr = 0 is accepted and discarded; nothing is enqueued.
- B handshake:
  - Transfer occurs when b_valid & b_ready at the clock edge.
  - b_ready = (count < DEPTH), derived from registered count only.
  - When full, no push is accepted even if a pop occurs in the same cycle.
  - The mul/div unit holds b_valid/b_addr/b_data stable until the transfer.
- Push and pop in the same cycle (not full): count is unchanged, and FIFO order is preserved. An entry pushed in cycle n is eligible to pop no earlier than cycle n+1; there is no bypass.
- Pointers wrap modulo DEPTH.
- busy_mask:
  - Combinational OR of one-hot decodes of the addresses of valid entries, from registered FIFO state.
  - Duplicate addresses are allowed. A bit clears only when no remaining entry targets that register.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and A wins arbitration.
  - It clears on any pop, or whenever the FIFO is empty; it saturates at STARVE_LIMIT.
  - stall_req is registered, and is 1 while the counter equals STARVE_LIMIT.
  - The pipeline guarantees a_valid = 0 while stall_req = 1. The resulting pop clears the counter, and stall_req falls on the next edge.
- Reset mid-operation: FIFO contents are dropped, and busy_mask and stall_req clear immediately (asynchronously).

Test Plan:
1. Reset then idle: hold rst = 0 for 2 cycles, release -> we = 0, busy_mask = 0, b_ready = 1, stall_req = 0.
2. Pipeline only: a_valid = 1, a_addr = 5, a_data = 0x12345678 for 1 cycle -> next cycle we = 1, waddr = 5, wd = 0x12345678; reading x5 from reg_files afterwards returns 0x12345678.
3. Contention:
   - Stimulus: b (addr 10, 0xABCDEF12) is pushed while a_valid = 1 with addr 3 for 2 cycles, then a_valid = 0.
   - Response: two A writes; busy_mask = 0x00000400 during contention; then we = 1, waddr = 10, wd = 0xABCDEF12; busy_mask returns to 0.
4. Full FIFO:
   - Stimulus: with a_valid held at 1 (addr 1), push b addr 7 then addr 8.
   - Response: b_ready = 0 after the second push, and a third b_valid (addr 9) stalls.
   - After a_valid drops, writes occur in order 7, 8, 9.
5. Starvation: with a_valid = 1 continuously and 1 entry queued -> stall_req = 1 after 4 losing cycles. The bench drops a_valid, the entry is written, and stall_req returns to 0.
6. x0 and reset:
   - b push with addr 0 -> count unchanged, no write.
   - a_valid with addr 0 while the FIFO holds addr 4 -> entry 4 is written in that slot.
   - rst pulsed low with 2 entries queued -> busy_mask = 0 and we = 0 immediately.
